// File: rtl/amba_apb_pkg.sv
// amba_apb_pkg: shared widths, slave-select bit and master FSM state type
package amba_apb_pkg;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int OFF_W     = 8;
    localparam int MEM_DEPTH = 1 << OFF_W;
    localparam int SEL_BIT   = 8;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: zero-wait-state 256x8 APB memory slave
// ports: pclk/preset clock and async reset; psel, penable, pwrite, paddr, pwdata APB request;
//        prdata read data (0 unless selected for a read); pready always ready in ACCESS
module apb_mem_slave
    import amba_apb_pkg::*;
(
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [OFF_W-1:0]  paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready
);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int k = 0; k < MEM_DEPTH; k++) mem_q[k] <= '0;
        end else if (psel && penable && pwrite) begin
            mem_q[paddr] <= pwdata;
        end
    end

    // zeroing when idle lets the master OR the slave buses together
    assign prdata = (psel && !pwrite) ? mem_q[paddr] : '0;
    assign pready = psel && penable;
endmodule

// File: rtl/amba_apb_top.sv
// amba_apb_top: APB master FSM driving two 256x8 memory slaves
// ports: pclk/preset clock and async reset; transfer, mpwrite, apb_write_paddr, apb_write_data,
//        apb_read_paddr user command; prdata selected slave bus; apb_read_data_out last read;
//        psel one-hot slave select; penable ACCESS phase
module amba_apb_top
    import amba_apb_pkg::*;
(
    input  logic              pclk,
    input  logic              preset,
    input  logic              transfer,
    input  logic              mpwrite,
    input  logic [ADDR_W-1:0] apb_write_paddr,
    input  logic [DATA_W-1:0] apb_write_data,
    input  logic [ADDR_W-1:0] apb_read_paddr,
    output logic [DATA_W-1:0] prdata,
    output logic [DATA_W-1:0] apb_read_data_out,
    output logic [1:0]        psel,
    output logic              penable
);
    apb_state_e        state_q, state_d;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q, rdata_q;
    logic              launch;
    logic [1:0]        pready;
    logic [DATA_W-1:0] prdata_s [2];

    // SETUP always advances; IDLE and ACCESS both launch a new transfer on request
    always_comb begin
        state_d = (state_q == SETUP) ? ACCESS : (transfer ? SETUP : IDLE);
        launch  = transfer && (state_q != SETUP);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (launch) begin
                pwrite_q <= mpwrite;
                paddr_q  <= mpwrite ? apb_write_paddr : apb_read_paddr;
                pwdata_q <= apb_write_data;
            end
            if (penable && !pwrite_q && |pready) rdata_q <= prdata;
        end
    end

    assign psel              = (state_q == IDLE) ? 2'b00 : (paddr_q[SEL_BIT] ? 2'b10 : 2'b01);
    assign penable           = (state_q == ACCESS);
    assign prdata            = prdata_s[0] | prdata_s[1];
    assign apb_read_data_out = rdata_q;

    for (genvar i = 0; i < 2; i++) begin : g_slv
        apb_mem_slave u_slv (
            .pclk   (pclk),
            .preset (preset),
            .psel   (psel[i]),
            .penable(penable),
            .pwrite (pwrite_q),
            .paddr  (paddr_q[OFF_W-1:0]),
            .pwdata (pwdata_q),
            .prdata (prdata_s[i]),
            .pready (pready[i])
        );
    end
endmodule

// File: tb/tb_amba_apb_top.sv
// tb_amba_apb_top: scoreboard bench for amba_apb_top against a flat memory model
module tb_amba_apb_top;
    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       transfer = 1'b0;
    logic       mpwrite = 1'b0;
    logic [8:0] apb_write_paddr = '0;
    logic [7:0] apb_write_data = '0;
    logic [8:0] apb_read_paddr = '0;
    logic [7:0] prdata, apb_read_data_out;
    logic [1:0] psel;
    logic       penable;

    amba_apb_top dut (
        .pclk(pclk), .preset(preset), .transfer(transfer), .mpwrite(mpwrite),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .prdata(prdata),
        .apb_read_data_out(apb_read_data_out), .psel(psel), .penable(penable)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit         wr;
        logic [8:0] addr;
        logic [7:0] data;
    } cmd_t;

    cmd_t       q[$];
    logic [7:0] mem_m [512];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 512; k++) mem_m[k] = 8'h00;
        q.delete();
    endtask

    task automatic scramble();
        apb_write_paddr = 9'($urandom);
        apb_write_data  = 8'($urandom);
        apb_read_paddr  = 9'($urandom);
        mpwrite         = 1'($urandom);
    endtask

    // called right after an edge; on return the DUT is in ACCESS for this command
    task automatic issue(input bit wr, input logic [8:0] a, input logic [7:0] d, input bit last);
        cmd_t c;
        scramble();
        mpwrite = wr;
        if (wr) begin
            apb_write_paddr = a;
            apb_write_data  = d;
        end else begin
            apb_read_paddr = a;
        end
        c.wr   = wr;
        c.addr = a;
        c.data = wr ? d : mem_m[a];
        if (wr) mem_m[a] = d;
        q.push_back(c);
        transfer = 1'b1;
        @(posedge pclk); #1;
        scramble();
        @(posedge pclk); #1;
        if (last) transfer = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    cmd_t       cur;
    bit         ph = 0;
    bit         rd_upd = 0;
    logic [7:0] rd_val = '0;
    logic [7:0] exp_rdo = '0;
    logic [1:0] exp_sel = '0;

    always @(negedge pclk) begin
        if (preset) begin
            ph      = 0;
            rd_upd  = 0;
            exp_rdo = '0;
        end else begin
            if (rd_upd) begin
                exp_rdo = rd_val;
                rd_upd  = 0;
            end
            chk("read_data_out", apb_read_data_out, exp_rdo);
            if (ph) begin
                chk("access_penable", penable, 1);
                chk("access_psel", psel, exp_sel);
                chk("access_prdata", prdata, cur.wr ? 8'h00 : cur.data);
                if (!cur.wr) begin
                    rd_upd = 1;
                    rd_val = cur.data;
                end
                ph = 0;
            end else if (psel != 2'b00) begin
                chk("setup_penable", penable, 0);
                if (q.size() == 0) chk("unexpected_setup", psel, 0);
                else begin
                    cur     = q.pop_front();
                    exp_sel = cur.addr[8] ? 2'b10 : 2'b01;
                    chk("setup_psel", psel, exp_sel);
                    ph = 1;
                end
            end else begin
                chk("idle_penable", penable, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        @(posedge pclk); #1;
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_rdo", apb_read_data_out, 0);
        preset = 1'b0;
        issue(1, 9'h012, 8'hA5, 1); idle(1);
        #50;
        preset = 1'b1;
        #1;
        chk("async_reset_psel", psel, 0);
        chk("async_reset_penable", penable, 0);
        chk("async_reset_rdo", apb_read_data_out, 0);
        clear_model();
        @(posedge pclk); #1;
        preset = 1'b0;
        idle(1);
        issue(1, 9'h012, 8'hA5, 1); idle(1);
        issue(0, 9'h012, 8'h00, 1); idle(1);
        issue(1, 9'h112, 8'h3C, 1); idle(1);
        issue(0, 9'h012, 8'h00, 1); idle(1);
        issue(0, 9'h112, 8'h00, 1); idle(2);
        issue(1, 9'h030, 8'h11, 0);
        issue(0, 9'h030, 8'h00, 0);
        issue(1, 9'h131, 8'h22, 0);
        issue(0, 9'h131, 8'h00, 1); idle(1);
        mpwrite = 1'b1; apb_write_paddr = 9'h020; apb_write_data = 8'h77; transfer = 1'b1;
        q.push_back('{1'b1, 9'h020, 8'h77});
        @(posedge pclk); #1;
        transfer = 1'b0;
        @(posedge pclk); #2;
        preset = 1'b1;
        #1;
        chk("abort_psel", psel, 0);
        chk("abort_penable", penable, 0);
        clear_model();
        @(posedge pclk); #1;
        preset = 1'b0;
        idle(1);
        issue(0, 9'h020, 8'h00, 1); idle(1);
        issue(0, 9'h0FF, 8'h00, 1); idle(1);
        for (int i = 0; i < 300; i++) begin
            bit         wr, last;
            logic [8:0] a;
            wr   = 1'($urandom);
            a    = {1'($urandom), 4'b0000, 4'($urandom)};
            last = ($urandom_range(0, 2) == 0) || (i == 299);
            issue(wr, a, 8'($urandom), last);
            if (last) idle($urandom_range(1, 3));
        end
        idle(2);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
